// File: rtl/multi_commit_rob_pkg.sv
// rtl/multi_commit_rob_pkg.sv - shared ROB configuration: kind encodings, register id width, default sizes
package multi_commit_rob_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_COMMIT_W = 2;
    localparam int REG_W        = 5;

    typedef enum logic [1:0] {
        KIND_NORMAL = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2
    } kind_e;

endpackage

// File: rtl/multi_commit_rob_retire_select.sv
// rtl/multi_commit_rob_retire_select.sv - head-relative retire run length and mispredict cut
module rob_retire_select
    import multi_commit_rob_pkg::*;
#(
    parameter int COMMIT_W = DEF_COMMIT_W,
    parameter int RC_W     = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] ready_i,
    input  kind_e               kind_i [COMMIT_W],
    input  logic [COMMIT_W-1:0] mispredict_i,
    output logic [RC_W-1:0]     retire_cnt_o,
    output logic                cut_o
);

    logic stop;

    // Count ready slots from head; a non-ready slot or a mispredicted branch ends the run.
    always_comb begin
        retire_cnt_o = '0;
        cut_o        = 1'b0;
        stop         = 1'b0;
        for (int s = 0; s < COMMIT_W; s++) begin
            if (!stop) begin
                if (ready_i[s]) begin
                    retire_cnt_o = retire_cnt_o + 1'b1;
                    if (kind_i[s] == KIND_BRANCH && mispredict_i[s]) begin
                        cut_o = 1'b1;
                        stop  = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_commit_rob.sv
// rtl/multi_commit_rob.sv - reorder buffer with multi-channel writeback and multi-slot in-order commit
module multi_commit_rob
    import multi_commit_rob_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ID_W     = 5,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = DEF_COMMIT_W,
    parameter int XLEN     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    output logic                     full,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_kind,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic [XLEN-1:0]          issue_pred_pc,
    output logic [ID_W-1:0]          issue_dest,
    input  logic [ID_W-1:0]          qj,
    input  logic [ID_W-1:0]          qk,
    output logic                     vj_valid,
    output logic                     vk_valid,
    output logic [XLEN-1:0]          vj,
    output logic [XLEN-1:0]          vk,
    input  logic [NUM_WB*ID_W-1:0]   wb_dest,
    input  logic [NUM_WB*XLEN-1:0]   wb_value,
    input  logic [NUM_WB*XLEN-1:0]   wb_next_pc,
    output logic [COMMIT_W-1:0]      commit_valid,
    output logic [COMMIT_W*ID_W-1:0] commit_dest,
    output logic [COMMIT_W*REG_W-1:0] commit_rd,
    output logic [COMMIT_W*XLEN-1:0] commit_value,
    output logic                     flush_out,
    output logic [XLEN-1:0]          flush_pc,
    input  logic                     flush_in
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RC_W  = $clog2(COMMIT_W + 1);

    // Ids run 1..DEPTH; advancing past DEPTH wraps back to 1.
    function automatic logic [ID_W-1:0] id_add(input logic [ID_W-1:0] id, input int off);
        int t;
        t = (int'(id) - 1 + off) % DEPTH;
        return ID_W'(t + 1);
    endfunction

    function automatic logic [IDX_W-1:0] id_idx(input logic [ID_W-1:0] id);
        return IDX_W'(int'(id) - 1);
    endfunction

    logic [ID_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DEPTH-1:0]          ready_q, ready_d;
    logic [COMMIT_W-1:0]       commit_valid_q, commit_valid_d;
    logic [COMMIT_W*ID_W-1:0]  commit_dest_q, commit_dest_d;
    logic [COMMIT_W*REG_W-1:0] commit_rd_q, commit_rd_d;
    logic [COMMIT_W*XLEN-1:0]  commit_value_q, commit_value_d;
    logic                      flush_out_q, flush_out_d;
    logic [XLEN-1:0]           flush_pc_q, flush_pc_d;

    kind_e            kind_q    [DEPTH];
    logic [REG_W-1:0] rd_q      [DEPTH];
    logic [XLEN-1:0]  pred_pc_q [DEPTH];
    logic [XLEN-1:0]  value_q   [DEPTH];
    logic [XLEN-1:0]  next_pc_q [DEPTH];

    logic [ID_W-1:0]     slot_id    [COMMIT_W];
    logic [IDX_W-1:0]    slot_idx   [COMMIT_W];
    kind_e               slot_kind  [COMMIT_W];
    logic [COMMIT_W-1:0] slot_ready;
    logic [COMMIT_W-1:0] slot_mis;
    logic [RC_W-1:0]     retire_cnt;
    logic                cut;

    logic [ID_W-1:0]   wb_id  [NUM_WB];
    logic [IDX_W-1:0]  wb_idx [NUM_WB];
    logic [NUM_WB-1:0] wb_hit;

    logic              alloc, wb_en, flush_any;
    logic [ID_W-1:0]   op_tag [2];
    logic [1:0]        op_valid;
    logic [XLEN-1:0]   op_val [2];

    assign full         = (count_q == CNT_W'(DEPTH));
    assign issue_dest   = tail_q;
    assign commit_valid = commit_valid_q;
    assign commit_dest  = commit_dest_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign flush_out    = flush_out_q;
    assign flush_pc     = flush_pc_q;

    assign op_tag[0] = qj;
    assign op_tag[1] = qk;
    assign vj_valid  = op_valid[0];
    assign vk_valid  = op_valid[1];
    assign vj        = op_val[0];
    assign vk        = op_val[1];

    // Gather the COMMIT_W oldest live entries as head-relative slots.
    always_comb begin
        for (int s = 0; s < COMMIT_W; s++) begin
            slot_id[s]    = id_add(head_q, s);
            slot_idx[s]   = id_idx(slot_id[s]);
            slot_kind[s]  = kind_q[slot_idx[s]];
            slot_ready[s] = ready_q[slot_idx[s]] && (CNT_W'(s) < count_q);
            slot_mis[s]   = next_pc_q[slot_idx[s]] != pred_pc_q[slot_idx[s]];
        end
    end

    rob_retire_select #(
        .COMMIT_W (COMMIT_W),
        .RC_W     (RC_W)
    ) u_retire_select (
        .ready_i      (slot_ready),
        .kind_i       (slot_kind),
        .mispredict_i (slot_mis),
        .retire_cnt_o (retire_cnt),
        .cut_o        (cut)
    );

    // Decode writeback channels; id 0 or out-of-range ids are idle.
    always_comb begin
        for (int i = 0; i < NUM_WB; i++) begin
            wb_id[i]  = wb_dest[i*ID_W +: ID_W];
            wb_idx[i] = id_idx(wb_id[i]);
            wb_hit[i] = (wb_id[i] != '0) && (int'(wb_id[i]) <= DEPTH);
        end
    end

    // Operand lookup: tag 0 is a constant, stored results beat bypass, lowest channel bypass wins.
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            op_valid[o] = 1'b0;
            op_val[o]   = '0;
            if (op_tag[o] == '0) begin
                op_valid[o] = 1'b1;
            end else if (int'(op_tag[o]) <= DEPTH) begin
                if (ready_q[id_idx(op_tag[o])]) begin
                    op_valid[o] = 1'b1;
                    op_val[o]   = value_q[id_idx(op_tag[o])];
                end else begin
                    for (int i = NUM_WB - 1; i >= 0; i--) begin
                        if (wb_hit[i] && wb_id[i] == op_tag[o]) begin
                            op_valid[o] = 1'b1;
                            op_val[o]   = wb_value[i*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    // Next-state: retire from head, allocate at tail, apply writebacks, then let a flush override.
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        ready_d        = ready_q;
        commit_valid_d = '0;
        commit_dest_d  = commit_dest_q;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        flush_out_d    = 1'b0;
        flush_pc_d     = flush_pc_q;
        flush_any      = rdy && (flush_in || cut);
        alloc          = rdy && issue_valid && !full && !flush_any;
        wb_en          = rdy && !flush_any;
        if (rdy) begin
            for (int s = 0; s < COMMIT_W; s++) begin
                if (RC_W'(s) < retire_cnt) begin
                    commit_valid_d[s]                  = (slot_kind[s] == KIND_NORMAL);
                    commit_dest_d[s*ID_W +: ID_W]      = slot_id[s];
                    commit_rd_d[s*REG_W +: REG_W]      = rd_q[slot_idx[s]];
                    commit_value_d[s*XLEN +: XLEN]     = value_q[slot_idx[s]];
                    ready_d[slot_idx[s]]               = 1'b0;
                    if (slot_kind[s] == KIND_BRANCH && slot_mis[s]) begin
                        flush_pc_d = next_pc_q[slot_idx[s]];
                    end
                end
            end
            head_d  = id_add(head_q, int'(retire_cnt));
            count_d = count_q + CNT_W'(alloc) - CNT_W'(retire_cnt);
            if (alloc) begin
                ready_d[id_idx(tail_q)] = 1'b0;
                tail_d                  = id_add(tail_q, 1);
            end
            if (wb_en) begin
                for (int i = 0; i < NUM_WB; i++) begin
                    if (wb_hit[i]) begin
                        ready_d[wb_idx[i]] = 1'b1;
                    end
                end
            end
            if (flush_any) begin
                head_d      = ID_W'(1);
                tail_d      = ID_W'(1);
                count_d     = '0;
                ready_d     = '0;
                flush_out_d = cut;
            end
        end
    end

    // Control state and registered retirement outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= ID_W'(1);
            tail_q         <= ID_W'(1);
            count_q        <= '0;
            ready_q        <= '0;
            commit_valid_q <= '0;
            commit_dest_q  <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            flush_out_q    <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            ready_q        <= ready_d;
            commit_valid_q <= commit_valid_d;
            commit_dest_q  <= commit_dest_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            flush_out_q    <= flush_out_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Entry payload; validity is tracked by ready/count, so no reset is needed. Lowest channel writes last.
    always_ff @(posedge clk) begin
        if (alloc) begin
            kind_q[id_idx(tail_q)]    <= kind_e'(issue_kind);
            rd_q[id_idx(tail_q)]      <= issue_rd;
            pred_pc_q[id_idx(tail_q)] <= issue_pred_pc;
        end
        if (wb_en) begin
            for (int i = NUM_WB - 1; i >= 0; i--) begin
                if (wb_hit[i]) begin
                    value_q[wb_idx[i]]   <= wb_value[i*XLEN +: XLEN];
                    next_pc_q[wb_idx[i]] <= wb_next_pc[i*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: doc/multi_commit_rob.md
MULTI_COMMIT_ROB -- requirements
Module: multi_commit_rob

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries; ids 1..DEPTH, id 0 = "none".
REQ-002 SHALL have parameter ID_W, default 5, id width; must satisfy 2^ID_W > DEPTH.
REQ-003 SHALL have parameter NUM_WB, default 2, number of writeback channels.
REQ-004 SHALL have parameter COMMIT_W, default 2, maximum retirements per cycle.
REQ-005 SHALL have parameter XLEN, default 32, data and PC width.
REQ-006 SHALL have ports:
  clk  in  1  clock.
  rst_n  in  1  reset; asynchronous, active-low.
  rdy  in  1  global enable; low freezes all state.
  full  out  1  high when count == DEPTH.
  issue_valid  in  1  allocate one entry.
  issue_kind  in  2  0 = normal, 1 = branch, 2 = store.
  issue_rd  in  5  destination register.
  issue_pred_pc  in  XLEN  predicted next PC (branch only).
  issue_dest  out  ID_W  tail id; the id the next allocation receives.
  qj / qk  in  ID_W  operand tags to look up.
  vj_valid / vk_valid  out  1  operand value available.
  vj / vk  out  XLEN  operand value.
  wb_dest  in  NUM_WB*ID_W  per-channel completing id; 0 = idle.
  wb_value  in  NUM_WB*XLEN  per-channel result.
  wb_next_pc  in  NUM_WB*XLEN  per-channel actual next PC.
  commit_valid  out  COMMIT_W  per-slot retirement of a register-writing entry.
  commit_dest  out  COMMIT_W*ID_W  retired ids.
  commit_rd  out  COMMIT_W*5  retired destination registers.
  commit_value  out  COMMIT_W*XLEN  retired values.
  flush_out  out  1  one-cycle mispredict flush pulse.
  flush_pc  out  XLEN  redirect PC.
  flush_in  in  1  external flush request.

Function
REQ-007 SHALL allocate at tail when issue_valid && !full && rdy; issue_valid while full SHALL be ignored.
REQ-008 SHALL advance head and tail modulo DEPTH over ids 1..DEPTH, wrapping DEPTH -> 1; count range 0..DEPTH.
REQ-009 SHALL update count by (allocated - retired) in the same cycle; allocate and retire together at full SHALL be legal only if retire >= 1 is computed from pre-edge state, and full SHALL still block issue that cycle.
REQ-010 SHALL mark entry wb_dest[i] ready and store value and next PC on the edge following the writeback; if two channels name the same id, the lowest channel index wins.
REQ-011 SHALL resolve operand lookup combinationally: q == 0 -> valid=1, value 0; entry ready -> stored value; a same-cycle wb_dest match -> bypassed wb_value (lowest channel wins); otherwise valid=0.
REQ-012 SHALL retire, per cycle, the longest run of up to COMMIT_W consecutive ready entries starting at head, stopping at the first non-ready entry.
REQ-013 SHALL register retirement outputs: writeback at edge t makes the entry ready, commit outputs appear after edge t+1 (two-cycle writeback-to-commit latency when the entry is at head).
REQ-014 SHALL set commit_valid only for normal entries; store and branch slots retire with commit_valid=0.
REQ-015 SHALL, when a retiring branch has actual next PC != predicted PC, end the retire run at that branch, pulse flush_out for one cycle with flush_pc = actual PC, and discard all younger entries.
REQ-016 SHALL, on flush_out or flush_in, set head = tail = 1, count = 0, clear all ready bits, and ignore issue and writeback in that cycle; flush_in SHALL NOT assert flush_out.
REQ-017 SHALL hold all state and drive commit_valid = 0 and flush_out = 0 while rdy is low.

Reset
REQ-018 SHALL, on rst_n low, immediately set head = tail = 1 and count = 0, clear all ready bits, and drive full, commit_valid, and flush_out low; commit_dest, commit_rd, commit_value, and flush_pc SHALL reset to 0.

Structure
REQ-019 SHALL take kind encodings, register-id width, and the DEPTH/COMMIT_W defaults from the shared config header.
REQ-020 SHALL instantiate one sub-module, rob_retire_select, which computes the retire count and branch cut from head-relative ready and kind vectors.

Verification
REQ-021 Fill 16 normal entries -> full=1 after the 16th allocation, issue_dest wraps to 1 after id 16, and a 17th issue is ignored.
REQ-022 Ids 1 and 2 written back in the same cycle on channels 0 and 1 -> two cycles later commit_valid=2'b11 with ids 1 and 2 and their values.
REQ-023 Branch id 1 with pred 0x104 and actual 0x200, plus ready id 2 -> id 1 retires alone, flush_out pulses with flush_pc=0x200, and the next issue_dest=1.
REQ-024 qj=3 with wb_dest[1]=3 and value 0xABCD in the same cycle -> vj_valid=1, vj=0xABCD.
REQ-025 Id 1 not ready and id 2 ready -> no commit; after id 1 completes, both retire in order in one cycle.
REQ-026 rst_n dropped mid-stream with 5 entries live -> outputs clear without a clock edge, and issue_dest=1 after release.
